// File: rtl/vram_arbiter.sv
// Text VRAM port arbiter: VGA cell fetch has priority, CPU uses the idle cycles.
// Define VRAM_ARB_POSTED_WRITE_EN to post CPU writes into a one-entry buffer.
module vram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_rdn,
  input  logic [31:0]       vga_addr,
  output logic [DATA_W-1:0] vram_out,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
`ifdef VRAM_ARB_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] hold, rq_data, pb_data, rdata;
  logic [ADDR_W-1:0] last_addr, rq_addr, pb_addr;
  logic [ADDR_W-1:0] vga_word, cpu_word;
  logic hold_valid, rq_we, pb_valid;
  logic vga_need, cpu_own, drain, serve, post, take;
  logic unused;

  assign unused = ^{vga_addr[31:ADDR_W+2], vga_addr[1:0],
                    cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                    cpu_wdata[31:DATA_W]};

  assign vga_word = vga_addr[ADDR_W+1:2];
  assign cpu_word = cpu_addr[ADDR_W+1:2];
  assign vga_need = !vga_rdn &&
                    (!hold_valid || vga_word != last_addr);

  // A pending posted write takes the CPU slot before any queued request.
  assign cpu_own = !vga_need && (state == WAIT || pb_valid);
  assign drain   = cpu_own && pb_valid;
  assign serve   = cpu_own && state == WAIT && !pb_valid;
  assign post    = POSTED && state == IDLE && cpu_req &&
                   cpu_we && !pb_valid;
  assign take    = state == IDLE && cpu_req && !post;

  assign vram_out  = vga_need ? ram_dout : hold;
  assign cpu_ready = state == DONE;
  assign cpu_rdata = {{(32-DATA_W){1'b0}}, rdata};

  always_comb begin
    ram_addr = vga_word;
    ram_we   = 1'b0;
    ram_din  = rq_data;
    if (drain) begin
      ram_addr = pb_addr;
      ram_we   = 1'b1;
      ram_din  = pb_data;
    end else if (serve) begin
      ram_addr = rq_addr;
      ram_we   = rq_we;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (post)      state_n = DONE;
        else if (take) state_n = WAIT;
      end
      WAIT:    if (serve) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      last_addr  <= '0;
      hold_valid <= 1'b0;
      rq_we      <= 1'b0;
      rq_addr    <= '0;
      rq_data    <= '0;
      pb_valid   <= 1'b0;
      pb_addr    <= '0;
      pb_data    <= '0;
      rdata      <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        rq_we   <= cpu_we;
        rq_addr <= cpu_word;
        rq_data <= cpu_wdata[DATA_W-1:0];
      end
      if (post) begin
        pb_valid <= 1'b1;
        pb_addr  <= cpu_word;
        pb_data  <= cpu_wdata[DATA_W-1:0];
      end else if (drain) begin
        pb_valid <= 1'b0;
      end
      if (serve && !rq_we)
        rdata <= ram_dout;
      // Snoop keeps the displayed cell coherent with CPU writes.
      if (vga_need) begin
        hold       <= ram_dout;
        last_addr  <= vga_word;
        hold_valid <= 1'b1;
      end else if (ram_we && ram_addr == last_addr) begin
        hold <= ram_din;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural async-read VRAM.
// Build with VRAM_ARB_POSTED_WRITE_EN to exercise the posted-write mode.
module tb_vram_arbiter;
  logic        clk, reset, vga_rdn;
  logic [31:0] vga_addr, cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_req, cpu_we, cpu_ready;
  logic [18:0] vram_out, ram_din, ram_dout;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [18:0] mem [2048];
  int passed = 0;
  int fails  = 0;
  int total  = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .vram_out(vram_out), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0; reset = 1; vga_rdn = 1; vga_addr = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 2048; i++) mem[i] <= 19'h50000 + 19'(i);
    cyc(); cyc(); #2;
    chk("rst_ready", 32'(cpu_ready), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_vram", 32'(vram_out), 0);
    chk("rst_rdata", cpu_rdata, 0);
    cyc(); reset = 0;

    // cell fetch
    cyc(); vga_rdn = 0; vga_addr = 0; #2;
    chk("fetch0_addr", 32'(ram_addr), 0);
    chk("fetch0_out", 32'(vram_out), 32'h50000);
    for (int i = 1; i < 16; i++) begin
      cyc();
      if (i == 1) mem[0] <= 19'h0;
      #2;
      chk("cell0_hold", 32'(vram_out), 32'h50000);
    end
    cyc(); vga_addr = 32'h4; #2;
    chk("fetch1_addr", 32'(ram_addr), 1);
    chk("fetch1_out", 32'(vram_out), 32'h50001);
    cyc(); #2;
    chk("cell1_hold", 32'(vram_out), 32'h50001);

    // idle write during blanking
    cyc(); vga_rdn = 1; cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h40; cpu_wdata = 32'h70041; #2;
    chk("wr_n0_ready", 32'(cpu_ready), 0);
    cyc(); #2;
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_addr), 32'h10);
    chk("wr_din", 32'(ram_din), 32'h70041);
`ifdef VRAM_ARB_POSTED_WRITE_EN
    chk("wr_ready_n1", 32'(cpu_ready), 1);
    cyc(); cpu_req = 0; #2;
    chk("wr_ready_n2", 32'(cpu_ready), 0);
`else
    chk("wr_ready_n1", 32'(cpu_ready), 0);
    cyc(); #2;
    chk("wr_ready_n2", 32'(cpu_ready), 1);
    chk("wr_we_n2", 32'(ram_we), 0);
    cyc(); cpu_req = 0; #2;
`endif
    chk("wr_mem", 32'(mem[16]), 32'h70041);

    // collision: VGA address changes in the first WAIT cycle
    cyc(); vga_rdn = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; #2;
    chk("blank_hold", 32'(vram_out), 32'h50001);
    cyc(); vga_addr = 32'h8; #2;
    chk("col_vga_addr", 32'(ram_addr), 2);
    chk("col_vga_out", 32'(vram_out), 32'h50002);
    chk("col_vga_we", 32'(ram_we), 0);
    chk("col_ready1", 32'(cpu_ready), 0);
    cyc(); #2;
    chk("col_cpu_addr", 32'(ram_addr), 32'h10);
    chk("col_cpu_we", 32'(ram_we), 0);
    chk("col_hold", 32'(vram_out), 32'h50002);
    chk("col_ready2", 32'(cpu_ready), 0);
    cyc(); #2;
    chk("col_ready3", 32'(cpu_ready), 1);
    chk("col_rdata", cpu_rdata, 32'h70041);
    cyc(); cpu_req = 0; #2;
    chk("col_rdata_kept", cpu_rdata, 32'h70041);

    // snoop write to displayed word 2
    cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8;
    cpu_wdata = 32'h40042; #2;
    cyc(); #2;
    chk("snp_we", 32'(ram_we), 1);
    chk("snp_addr", 32'(ram_addr), 2);
    chk("snp_pre", 32'(vram_out), 32'h50002);
    cyc();
`ifdef VRAM_ARB_POSTED_WRITE_EN
    cpu_req = 0;
`endif
    #2;
    chk("snp_out", 32'(vram_out), 32'h40042);
`ifndef VRAM_ARB_POSTED_WRITE_EN
    chk("snp_ready", 32'(cpu_ready), 1);
    cyc(); cpu_req = 0; #2;
`endif
    cyc(); #2;
    chk("snp_stable", 32'(vram_out), 32'h40042);
    chk("snp_mem", 32'(mem[2]), 32'h40042);

    // reset while WAIT is blocked by a VGA fetch
    cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; #2;
    cyc(); vga_addr = 32'hC; #2;
    chk("mid_fetch_addr", 32'(ram_addr), 3);
    chk("mid_we", 32'(ram_we), 0);
    chk("mid_ready", 32'(cpu_ready), 0);
    reset = 1; vga_rdn = 1; vga_addr = 0; #2;
    chk("mrst_ready", 32'(cpu_ready), 0);
    chk("mrst_we", 32'(ram_we), 0);
    chk("mrst_addr", 32'(ram_addr), 0);
    chk("mrst_din", 32'(ram_din), 0);
    chk("mrst_vram", 32'(vram_out), 0);
    chk("mrst_rdata", cpu_rdata, 0);
    cyc(); #2;
    chk("mrst_ready2", 32'(cpu_ready), 0);
    cyc(); cpu_req = 0; reset = 0; #2;
    cyc(); #2;
    chk("mrst_ready3", 32'(cpu_ready), 0);
    chk("mrst_we3", 32'(ram_we), 0);

`ifdef VRAM_ARB_POSTED_WRITE_EN
    // posted write followed immediately by a read of the same word
    cyc(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80;
    cpu_wdata = 32'h31234; #2;
    cyc(); #2;
    chk("pw_ready", 32'(cpu_ready), 1);
    chk("pw_we", 32'(ram_we), 1);
    chk("pw_addr", 32'(ram_addr), 32'h20);
    cyc(); cpu_we = 0; cpu_wdata = 0; #2;
    cyc(); #2;
    chk("pr_addr", 32'(ram_addr), 32'h20);
    chk("pr_we", 32'(ram_we), 0);
    cyc(); #2;
    chk("pr_ready", 32'(cpu_ready), 1);
    chk("pr_rdata", cpu_rdata, 32'h31234);
    cyc(); cpu_req = 0; #2;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port arbiter for the 2048 x 19-bit text VRAM, shared between the VGA scan-out path and the CPU bus. The VGA reader has absolute priority but needs the port only once per 16-pixel character cell. A hold register serves the remaining pixels of each cell, and those idle cycles go to the CPU. The block sits between the bus decoder, the VRAM and the VGA text pipeline, and supplies that pipeline's `vram_out`.

## Interface
- `ADDR_W`, 11: VRAM word-address width.
- `DATA_W`, 19: VRAM word width; bits 18:16 are colour, bits 15:0 are the character index.

- `clk`  in  1: pixel/system clock.
- `reset`  in  1: asynchronous, active-high.
- `vga_rdn`  in  1: low = active display; VGA needs data.
- `vga_addr`  in  32: VGA byte address; word = `vga_addr[12:2]`.
- `vram_out`  out  DATA_W: character word for the current VGA address.
- `cpu_req`  in  1: CPU access request, sampled in IDLE only.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  32: CPU byte address; word = `cpu_addr[12:2]`.
- `cpu_wdata`  in  32: write data; bits 18:0 are used.
- `cpu_rdata`  out  32: read data, zero-extended from 19 bits; holds its value until the next read completes.
- `cpu_ready`  out  1: one-cycle completion pulse.
- `ram_addr`  out  ADDR_W: VRAM address.
- `ram_we`  out  1: VRAM write enable, written on the rising edge.
- `ram_din`  out  DATA_W: VRAM write data.
- `ram_dout`  in  DATA_W: VRAM asynchronous read data.

## Operation
- **Registers:** `hold` (DATA_W), `last_addr` (ADDR_W), `hold_valid`, CPU request registers (`rq_we`, `rq_addr`, `rq_data`), FSM state.
- **VGA need:** `vga_need = !vga_rdn && (!hold_valid || vga_word != last_addr)`.
- **Port owner (per cycle, combinational):**
  - VGA if `vga_need`.
  - Otherwise CPU if the FSM is in WAIT.
  - Otherwise idle, with `ram_addr` = VGA word.
- **VGA cycle:**
  - `ram_addr` = VGA word; `vram_out` = `ram_dout`.
  - On the edge: `hold <= ram_dout`, `last_addr <= vga_word`, `hold_valid <= 1`.
- **Non-VGA cycle:** `vram_out = hold`.
- **Write snoop:** a CPU write granted to `rq_addr == last_addr` also loads `hold <= rq_data[18:0]`, so the display never shows stale data.
- **CPU FSM:**
  - IDLE: on `cpu_req`, capture `cpu_we`/`cpu_addr`/`cpu_wdata` and go to WAIT.
  - WAIT: stay until the CPU owns the port. In the granted cycle:
    - Write: `ram_we=1`, `ram_din=rq_data[18:0]`.
    - Read: `cpu_rdata <= {13'b0, ram_dout}`.
    - Then go to DONE.
  - DONE: `cpu_ready=1` for one cycle, then IDLE. `cpu_req` is ignored in DONE.
- **Requester rule:** hold `cpu_req`/`cpu_addr`/`cpu_wdata` stable until `cpu_ready`. If `cpu_req` is still high in IDLE, a new access starts.
- **Blanking:** `vga_rdn` high leaves the hold contents valid; the CPU is never blocked.
- **Reset:** asynchronous.
  - State returns to IDLE; `hold`, `last_addr`, `hold_valid`, `cpu_rdata`, `cpu_ready`, `ram_we` all go to 0.
  - An in-flight request is dropped with no `cpu_ready`.
- `ram_we` is never asserted in a VGA-owned cycle.

## Timing
- VGA data path is combinational.
  - New-address cycle: `vram_out` follows `ram_dout`.
  - Following cycles: `vram_out` comes from `hold`.
- CPU latency from `cpu_req` sampled at edge N:
  - Minimum: grant in cycle N+1, `cpu_ready` in cycle N+2.
  - A VGA fetch adds exactly one cycle. The next fetch is at least 16 cycles later, so the maximum is N+3.
- Address change and CPU WAIT in the same cycle: VGA wins and the CPU is granted the next cycle.
- First active pixel after reset: `hold_valid=0` forces a VGA fetch.

## Configuration
- **`VRAM_ARB_POSTED_WRITE_EN` defined:** writes are posted.
  - A write sampled in IDLE goes to DONE directly (`cpu_ready` at N+1).
  - The write sits in a one-entry buffer and is drained at the next cycle the CPU owns the port, with snoop applied at drain.
  - A new request arriving while the buffer is full stays in WAIT until the drain completes. This applies to reads and writes, so order is preserved.
- **Not defined:** writes take the WAIT path exactly like reads.

## Test plan
- **Cell fetch:** reset, then `vga_rdn=0` with `vga_addr=0x0`, then `0x4` after 16 cycles. Required: `ram_addr` = 0 then 1 on exactly one cycle each; `vram_out` is stable across the 16 cycles of a cell.
- **Idle write:** CPU write addr `0x40`, data `0x7_0041`, during blanking. Required: `ram_we=1` with `ram_addr=0x10` at N+1; `cpu_ready` at N+2.
- **Collision:** CPU read of word `0x10` issued in the same cycle the VGA address changes. Required: VGA owns N+1, CPU owns N+2, `cpu_ready` at N+3, `cpu_rdata` = stored word zero-extended.
- **Snoop:** write `0x4_0042` to the word currently displayed. Required: `vram_out` = `0x4_0042` from the cycle after the write, with no extra VGA fetch.
- **Reset mid-operation:** assert `reset` while in WAIT. Required: no `cpu_ready`, no `ram_we`, all outputs 0.
- **Posted write** (`VRAM_ARB_POSTED_WRITE_EN` defined): write then immediately read the same address. Required: `cpu_ready` for the write at N+1; the read returns the new data.
